lfsr_range_gen: RTL and testbench



---
 rtl/lfsr_range_gen.sv | 136 +++++++++++++
 tb/tb_lfsr_range_gen.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_range_gen.sv
// lfsr_range_gen: parametrised Fibonacci LFSR with runtime seeding, zero-lockup
// recovery, and a request/valid front end that returns a value in [0, limit-1]
// by bounded rejection sampling. A request that exhausts MAX_TRIES candidates
// returns 0 with rnd_fallback set, so game logic never stalls indefinitely.
module lfsr_range_gen #(
  parameter int unsigned       WIDTH     = 8,
  parameter logic [WIDTH-1:0]  TAPS      = 8'hB8,
  parameter logic [WIDTH-1:0]  SEED      = 8'h01,
  parameter int unsigned       OUT_W     = 4,
  parameter int unsigned       MAX_TRIES = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             req,
  input  logic [OUT_W-1:0] limit,
  output logic             busy,
  output logic             rnd_valid,
  output logic [OUT_W-1:0] rnd_out,
  output logic             rnd_fallback,
  output logic [WIDTH-1:0] state_out
);

  // Counter must hold MAX_TRIES itself, since it increments on the last reject.
  localparam int unsigned CNT_W = $clog2(MAX_TRIES + 1);

  typedef enum logic {
    IDLE = 1'b0,
    GEN  = 1'b1
  } fsm_e;

  fsm_e             fsm_q, fsm_d;
  logic [WIDTH-1:0] state_q, state_d;
  logic [CNT_W-1:0] try_cnt_q, try_cnt_d;
  logic [OUT_W-1:0] limit_q, limit_d;
  logic             rnd_valid_q, rnd_valid_d;
  logic [OUT_W-1:0] rnd_out_q, rnd_out_d;
  logic             rnd_fallback_q, rnd_fallback_d;

  logic             step_en;
  logic             feedback;
  logic [OUT_W-1:0] cand;
  logic             accept;
  logic             last_try;

  assign step_en  = (fsm_q == GEN) || ((fsm_q == IDLE) && enable);
  assign feedback = ^(state_q & TAPS);
  // Candidate is the low bits of the pre-step register value.
  assign cand     = state_q[OUT_W-1:0];
  assign accept   = (limit_q == '0) || (cand < limit_q);
  assign last_try = (try_cnt_q == CNT_W'(MAX_TRIES - 1));

  // LFSR next state: seed load first, then lockup recovery, then stepping.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned; an unassigned path would infer a latch.
    state_d = state_q;
    if (seed_load) begin
      // A zero seed would lock the register up, so substitute the safe seed.
      state_d = (seed_in != '0) ? seed_in : SEED;
    end else if (state_q == '0) begin
      // All-zero is a fixed point of XOR feedback; never let it persist.
      state_d = SEED;
    end else if (step_en) begin
      state_d = {state_q[WIDTH-2:0], feedback};
    end
  end

  // Request FSM: latch the bound in IDLE, test one candidate per GEN cycle.
  always_comb begin
    fsm_d          = fsm_q;
    try_cnt_d      = try_cnt_q;
    limit_d        = limit_q;
    rnd_valid_d    = 1'b0;
    rnd_out_d      = rnd_out_q;
    rnd_fallback_d = 1'b0;

    unique case (fsm_q)
      IDLE: begin
        if (req) begin
          fsm_d     = GEN;
          limit_d   = limit;
          try_cnt_d = '0;
        end
      end
      GEN: begin
        if (accept) begin
          rnd_out_d   = cand;
          rnd_valid_d = 1'b1;
          fsm_d       = IDLE;
        end else begin
          try_cnt_d = try_cnt_q + CNT_W'(1);
          if (last_try) begin
            rnd_out_d      = '0;
            rnd_valid_d    = 1'b1;
            rnd_fallback_d = 1'b1;
            fsm_d          = IDLE;
          end
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of the others, independent of ordering.
    if (!rst_n) begin
      fsm_q          <= IDLE;
      state_q        <= SEED;
      try_cnt_q      <= '0;
      limit_q        <= '0;
      rnd_valid_q    <= 1'b0;
      rnd_out_q      <= '0;
      rnd_fallback_q <= 1'b0;
    end else begin
      fsm_q          <= fsm_d;
      state_q        <= state_d;
      try_cnt_q      <= try_cnt_d;
      limit_q        <= limit_d;
      rnd_valid_q    <= rnd_valid_d;
      rnd_out_q      <= rnd_out_d;
      rnd_fallback_q <= rnd_fallback_d;
    end
  end

  assign busy         = (fsm_q == GEN);
  assign rnd_valid    = rnd_valid_q;
  assign rnd_out      = rnd_out_q;
  assign rnd_fallback = rnd_fallback_q;
  assign state_out    = state_q;

endmodule

// File: tb/tb_lfsr_range_gen.sv
// Self-checking bench for lfsr_range_gen: a directed vector table, hand-written
// multi-cycle corner cases, and a randomized run against a transaction model.
module tb_lfsr_range_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable, seed_load, req;
  logic [7:0] seed_in;
  logic [3:0] limit;

  logic       busy_a, valid_a, fb_a;
  logic [3:0] out_a;
  logic [7:0] state_a;
  logic       busy_b, valid_b, fb_b;
  logic [3:0] out_b;
  logic [7:0] state_b;
  logic       busy_c, valid_c, fb_c;
  logic [3:0] out_c;
  logic [7:0] state_c;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Default configuration.
  lfsr_range_gen dut_a (
    .clk(clk), .rst_n(rst_n), .enable(enable), .seed_load(seed_load),
    .seed_in(seed_in), .req(req), .limit(limit), .busy(busy_a),
    .rnd_valid(valid_a), .rnd_out(out_a), .rnd_fallback(fb_a), .state_out(state_a)
  );

  // Short retry budget for the fallback path.
  lfsr_range_gen #(.MAX_TRIES(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .enable(enable), .seed_load(seed_load),
    .seed_in(seed_in), .req(req), .limit(limit), .busy(busy_b),
    .rnd_valid(valid_b), .rnd_out(out_b), .rnd_fallback(fb_b), .state_out(state_b)
  );

  // Tap mask without the MSB: state 0x80 shifts into all-zero.
  lfsr_range_gen #(.TAPS(8'h38)) dut_c (
    .clk(clk), .rst_n(rst_n), .enable(enable), .seed_load(seed_load),
    .seed_in(seed_in), .req(req), .limit(limit), .busy(busy_c),
    .rnd_valid(valid_c), .rnd_out(out_c), .rnd_fallback(fb_c), .state_out(state_c)
  );

  typedef struct {
    bit       en;
    bit       sl;
    bit [7:0] si;
    bit       rq;
    bit [3:0] lim;
    bit [7:0] st;
    bit       busy;
    bit       vld;
    bit [3:0] out;
    bit       fb;
  } vec_t;

  vec_t vecs[20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit en, input bit sl, input bit [7:0] si,
                       input bit rq, input bit [3:0] lim);
    enable = en; seed_load = sl; seed_in = si; req = rq; limit = lim;
  endtask

  // One rising edge, then settle on the falling edge for sampling.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    drive(0, 0, 8'h00, 0, 4'd0);
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  function automatic vec_t mk(bit en, bit sl, bit [7:0] si, bit rq, bit [3:0] lim,
                              bit [7:0] st, bit bz, bit vld, bit [3:0] out, bit fb);
    vec_t v;
    v.en = en; v.sl = sl; v.si = si; v.rq = rq; v.lim = lim;
    v.st = st; v.busy = bz; v.vld = vld; v.out = out; v.fb = fb;
    return v;
  endfunction

  // Reference step: shift left one place, feedback = parity of tapped bits.
  function automatic int ref_step(int s);
    return ((s * 2) % 256) + ($countones(s & 8'hB8) % 2);
  endfunction

  initial begin
    int vcount;
    // model state for the randomized run
    int m_state, m_gen, m_tries, m_lim, m_valid, m_out, m_fb;

    //                en sl si     rq lim  st     bz v  out fb
    vecs[0]  = mk(1, 0, 8'h00, 0, 0, 8'h02, 0, 0, 0, 0);
    vecs[1]  = mk(1, 0, 8'h00, 0, 0, 8'h04, 0, 0, 0, 0);
    vecs[2]  = mk(1, 0, 8'h00, 0, 0, 8'h08, 0, 0, 0, 0);
    vecs[3]  = mk(1, 0, 8'h00, 0, 0, 8'h11, 0, 0, 0, 0);
    vecs[4]  = mk(1, 0, 8'h00, 0, 0, 8'h23, 0, 0, 0, 0);
    vecs[5]  = mk(1, 0, 8'h00, 0, 0, 8'h47, 0, 0, 0, 0);
    vecs[6]  = mk(1, 0, 8'h00, 0, 0, 8'h8E, 0, 0, 0, 0);
    vecs[7]  = mk(0, 1, 8'h01, 0, 0, 8'h01, 0, 0, 0, 0);  // reseed to 01
    vecs[8]  = mk(0, 0, 8'h00, 1, 3, 8'h01, 1, 0, 0, 0);  // req limit=3, no step in IDLE
    vecs[9]  = mk(0, 0, 8'h00, 0, 0, 8'h02, 0, 1, 1, 0);  // accept 1
    vecs[10] = mk(0, 0, 8'h00, 0, 0, 8'h02, 0, 0, 1, 0);  // rnd_out held
    vecs[11] = mk(0, 1, 8'h08, 0, 0, 8'h08, 0, 0, 1, 0);
    vecs[12] = mk(0, 0, 8'h00, 1, 4, 8'h08, 1, 0, 1, 0);  // req limit=4
    vecs[13] = mk(0, 0, 8'h00, 0, 0, 8'h11, 1, 0, 1, 0);  // reject 8; limit change ignored
    vecs[14] = mk(0, 0, 8'h00, 0, 0, 8'h23, 0, 1, 1, 0);  // accept 1
    vecs[15] = mk(0, 1, 8'h00, 0, 0, 8'h01, 0, 0, 1, 0);  // zero seed -> SEED
    vecs[16] = mk(1, 0, 8'h00, 1, 0, 8'h02, 1, 0, 1, 0);  // req full range, free-run step
    vecs[17] = mk(0, 0, 8'h00, 1, 0, 8'h04, 0, 1, 2, 0);  // req while busy ignored
    vecs[18] = mk(0, 0, 8'h00, 1, 5, 8'h04, 1, 0, 2, 0);  // req during rnd_valid accepted
    vecs[19] = mk(0, 0, 8'h00, 0, 0, 8'h08, 0, 1, 4, 0);  // accept 4

    // Reset values.
    do_reset();
    check("reset_state", state_a, 8'h01);
    check("reset_busy", busy_a, 0);
    check("reset_valid", valid_a, 0);
    check("reset_out", out_a, 0);
    check("reset_fb", fb_a, 0);

    // Directed table.
    for (int i = 0; i < 20; i++) begin
      drive(vecs[i].en, vecs[i].sl, vecs[i].si, vecs[i].rq, vecs[i].lim);
      tick();
      check($sformatf("vec%0d_state", i), state_a, vecs[i].st);
      check($sformatf("vec%0d_busy", i), busy_a, vecs[i].busy);
      check($sformatf("vec%0d_valid", i), valid_a, vecs[i].vld);
      check($sformatf("vec%0d_out", i), out_a, vecs[i].out);
      check($sformatf("vec%0d_fb", i), fb_a, vecs[i].fb);
    end

    // Fallback after MAX_TRIES=4 rejects: candidates 1,2,4,8 vs limit 1.
    do_reset();
    drive(0, 0, 8'h00, 1, 4'd1);
    tick();
    drive(0, 0, 8'h00, 0, 4'd0);
    check("fb_busy_entry", busy_b, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("fb_no_valid%0d", i), valid_b, 0);
    end
    tick();
    check("fb_valid", valid_b, 1);
    check("fb_out", out_b, 0);
    check("fb_flag", fb_b, 1);
    check("fb_state", state_b, 8'h11);
    check("fb_busy_exit", busy_b, 0);
    tick();
    check("fb_valid_pulse", valid_b, 0);
    check("fb_flag_pulse", fb_b, 0);

    // Lockup recovery: 0x80 steps into zero, which is replaced by SEED.
    drive(0, 1, 8'h80, 0, 4'd0);
    tick();
    check("lock_load", state_c, 8'h80);
    drive(1, 0, 8'h00, 0, 4'd0);
    tick();
    check("lock_zero", state_c, 8'h00);
    tick();
    check("lock_recover", state_c, 8'h01);

    // Reset during GEN abandons the request.
    do_reset();
    drive(0, 1, 8'h08, 0, 4'd0);
    tick();
    drive(0, 0, 8'h00, 1, 4'd1);
    tick();
    drive(0, 0, 8'h00, 0, 4'd0);
    check("abort_busy", busy_a, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("abort_state", state_a, 8'h01);
    check("abort_busy_clr", busy_a, 0);
    vcount = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (valid_a) vcount++;
    end
    check("abort_no_valid", vcount, 0);
    // req held across the busy cycle yields exactly one result.
    vcount = 0;
    drive(0, 0, 8'h00, 1, 4'd2);
    tick();
    if (valid_a) vcount++;
    tick();
    if (valid_a) vcount++;
    check("rep_out", out_a, 1);
    drive(0, 0, 8'h00, 0, 4'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      if (valid_a) vcount++;
    end
    check("rep_one_valid", vcount, 1);

    // Randomized run against the transaction model.
    do_reset();
    m_state = 1; m_gen = 0; m_tries = 0; m_lim = 0; m_valid = 0; m_out = 0; m_fb = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bit       en, sl, rq;
      bit [7:0] si;
      bit [3:0] lim;
      int       stepping, cand, nxt;
      en  = ($urandom_range(0, 1) == 1);
      sl  = ($urandom_range(0, 15) == 0);
      si  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      rq  = ($urandom_range(0, 2) == 0);
      lim = 4'($urandom_range(0, 15));
      drive(en, sl, si, rq, lim);
      tick();

      stepping = m_gen || en;
      m_valid = 0;
      m_fb = 0;
      if (m_gen != 0) begin
        cand = m_state % 16;
        if (m_lim == 0 || cand < m_lim) begin
          m_valid = 1; m_out = cand; m_gen = 0;
        end else begin
          m_tries++;
          if (m_tries == 8) begin
            m_valid = 1; m_fb = 1; m_out = 0; m_gen = 0;
          end
        end
      end else if (rq) begin
        m_gen = 1; m_lim = lim; m_tries = 0;
      end
      if (sl) nxt = (si != 0) ? int'(si) : 1;
      else if (m_state == 0) nxt = 1;
      else if (stepping != 0) nxt = ref_step(m_state);
      else nxt = m_state;
      m_state = nxt;

      check("rnd_state", state_a, m_state);
      check("rnd_busy", busy_a, m_gen);
      check("rnd_valid", valid_a, m_valid);
      check("rnd_out", out_a, m_out);
      check("rnd_fb", fb_a, m_fb);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
